sprite_blitter: RTL and testbench

Sprite-fetch engine that drives the read side of the sprite ROM. On a `start` command it walks every address of one 96x96 sprite and issues reads against the ROM's 1-cycle registered port. It then pushes each returned 8-bit palette index into the frame-buffer write port, skipping transparent pixels, clipping at screen edges, and honouring back-pressure. It sits between the battle/overworld game FSM (command side) and the frame-buffer arbiter (pixel side).

---
 rtl/sprite_pkg.sv | 19 +
 rtl/blit_skid.sv | 61 ++++++
 rtl/sprite_blitter.sv | 159 +++++++++++++++
 tb/tb_sprite_blitter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and state type for the sprite blitter.
package sprite_pkg;

    localparam int SPR_W_DEFAULT = 96;
    localparam int SPR_H_DEFAULT = 96;
    localparam int FB_W_DEFAULT  = 640;
    localparam int FB_H_DEFAULT  = 480;
    localparam int SPR_PIXELS    = SPR_W_DEFAULT * SPR_H_DEFAULT;
    localparam int ROM_AW        = 14;
    localparam int FB_AW         = 19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_t;

endpackage

// File: rtl/blit_skid.sv
// Output register plus one-entry skid register with valid/ready handshake.
// The skid entry always refills the output register before new input does.
module blit_skid #(
    parameter int W = 27
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_payload,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_payload,
    output logic         skid_valid
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_pl_q, out_pl_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_pl_q, skid_pl_d;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_pl_d     = out_pl_q;
        skid_valid_d = skid_valid_q;
        skid_pl_d    = skid_pl_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pl_d     = skid_pl_q;
                skid_valid_d = in_valid;
                if (in_valid) skid_pl_d = in_payload;
            end else begin
                out_valid_d = in_valid;
                if (in_valid) out_pl_d = in_payload;
            end
        end else if (in_valid) begin
            // Output is stalled: park the returning pixel.
            skid_valid_d = 1'b1;
            skid_pl_d    = in_payload;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_q  <= 1'b0;
            out_pl_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_pl_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pl_q     <= out_pl_d;
            skid_valid_q <= skid_valid_d;
            skid_pl_q    <= skid_pl_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_payload = out_pl_q;
    assign skid_valid  = skid_valid_q;

endmodule

// File: rtl/sprite_blitter.sv
// Sprite-fetch engine: walks sprite ROM, clips/keys pixels, feeds the frame buffer.
// Optional horizontal mirroring is enabled with SPRITE_BLITTER_HFLIP_EN.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int         SPR_W       = SPR_W_DEFAULT,
    parameter int         SPR_H       = SPR_H_DEFAULT,
    parameter int         FB_W        = FB_W_DEFAULT,
    parameter int         FB_H        = FB_H_DEFAULT,
    parameter logic [7:0] TRANSPARENT = 8'h00
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
`ifdef SPRITE_BLITTER_HFLIP_EN
    input  logic              hflip,
`endif
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [7:0]        fb_data,
    input  logic              fb_ready
);

    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);

    blit_state_t       state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic              hflip_q, hflip_d, hflip_in;
    logic [ROM_AW-1:0] last_addr_q, last_addr_d;
    logic              inflight_q, inflight_d;
    logic [10:0]       sx_q, sx_d, sy_q, sy_d;

    logic [CW-1:0]     col_eff;
    logic [ROM_AW-1:0] cur_addr;
    logic [10:0]       cur_x, cur_y;
    logic [1:0]        occ;
    logic              hs, issue, keep, last_col, last_row;
    logic              out_valid, skid_valid;
    logic [FB_AW-1:0]  ret_addr;

`ifdef SPRITE_BLITTER_HFLIP_EN
    assign hflip_in = hflip;
`else
    assign hflip_in = 1'b0;
`endif

    assign col_eff  = hflip_q ? (CW'(SPR_W - 1) - col_q) : col_q;
    assign cur_addr = ROM_AW'(row_q) * ROM_AW'(SPR_W) + ROM_AW'(col_eff);
    assign cur_x    = 11'(pos_x_q) + 11'(col_q);
    assign cur_y    = 11'(pos_y_q) + 11'(row_q);
    assign last_col = (col_q == CW'(SPR_W - 1));
    assign last_row = (row_q == RW'(SPR_H - 1));

    // Never let more than two pixels be outstanding once this cycle's handshake retires.
    assign hs    = fb_we & fb_ready;
    assign occ   = 2'(inflight_q) + 2'(out_valid) + 2'(skid_valid);
    assign issue = (state_q == ST_RUN) && ((occ - 2'(hs)) < 2'd2);

    assign rom_addr = issue ? cur_addr : last_addr_q;

    assign keep     = inflight_q && (rom_data != TRANSPARENT)
                      && (sx_q < 11'(FB_W)) && (sy_q < 11'(FB_H));
    assign ret_addr = FB_AW'(sy_q) * FB_AW'(FB_W) + FB_AW'(sx_q);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        hflip_d     = hflip_q;
        last_addr_d = rom_addr;
        inflight_d  = issue;
        sx_d        = issue ? cur_x : sx_q;
        sy_d        = issue ? cur_y : sy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pos_x_d = pos_x;
                    pos_y_d = pos_y;
                    hflip_d = hflip_in;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (last_col && last_row) begin
                        row_d   = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && !out_valid && !skid_valid) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            hflip_q     <= 1'b0;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            hflip_q     <= hflip_d;
            last_addr_q <= last_addr_d;
            inflight_q  <= inflight_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
        end
    end

    blit_skid #(.W(FB_AW + 8)) u_skid (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .in_valid    (keep),
        .in_payload  ({ret_addr, rom_data}),
        .out_ready   (fb_ready),
        .out_valid   (out_valid),
        .out_payload ({fb_addr, fb_data}),
        .skid_valid  (skid_valid)
    );

    assign fb_we = out_valid;
    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: table of sprite runs checked against a
// pixel-level reference model, plus hand-written reset-abort and mirroring sequences.
module tb_sprite_blitter;
    import sprite_pkg::*;

    localparam int PAT_OPAQUE = 0;
    localparam int PAT_CHECK  = 1;
    localparam int PAT_RANDOM = 2;
    localparam int PAT_RAMP   = 3;

    typedef struct {
        int px;
        int py;
        int pat;
        bit rnd_ready;
        bit poke;
        bit flip;
        int exp_n;        // -1: take from model
        int exp_first;    // -1: take from model
        int exp_last;     // -1: take from model
        int exp_done;     // -1: not checked
        int exp_first_we; // -1: not checked
    } vec_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
`ifdef SPRITE_BLITTER_HFLIP_EN
    logic        hflip = 1'b0;
`endif
    logic        busy, done, fb_we;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_ready = 1'b1;

    sprite_blitter dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
`ifdef SPRITE_BLITTER_HFLIP_EN
        .hflip    (hflip),
`endif
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_ready (fb_ready)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Sprite ROM with a one-cycle registered read port.
    logic [7:0] rom_mem [0:SPR_PIXELS-1];
    always @(posedge Clk) rom_data <= rom_mem[int'(rom_addr) % SPR_PIXELS];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    wr_t exp_q[$];

    task automatic fill_rom(input int pat);
        for (int a = 0; a < SPR_PIXELS; a++) begin
            int r = a / 96;
            int c = a % 96;
            case (pat)
                PAT_OPAQUE: rom_mem[a] = 8'h11;
                PAT_CHECK:  rom_mem[a] = ((r + c) % 2 == 1) ? 8'h22 : 8'h00;
                PAT_RAMP:   rom_mem[a] = 8'(c);
                default:    rom_mem[a] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            endcase
        end
    endtask

    // Reference: every sprite pixel in raster order, keyed and clipped on the screen.
    task automatic build_expected(input int px, input int py, input bit flip);
        exp_q.delete();
        for (int r = 0; r < 96; r++) begin
            for (int c = 0; c < 96; c++) begin
                int x = px + c;
                int y = py + r;
                int d = int'(rom_mem[r * 96 + (flip ? 95 - c : c)]);
                if (d != 0 && x < 640 && y < 480) begin
                    wr_t w;
                    w.addr = y * 640 + x;
                    w.data = d;
                    exp_q.push_back(w);
                end
            end
        end
    endtask

    bit         mon_en = 1'b0;
    bit         addr_chk_en = 1'b0;
    int         start_cyc = 0;
    int         n_wr, first_addr, first_data, last_addr, first_we_rel, done_cnt, done_rel, exp_rom;
    bit         prev_stall;
    logic [18:0] prev_addr;
    logic [7:0]  prev_data;

    always @(negedge Clk) begin
        int  rel;
        wr_t e;
        if (mon_en) begin
            rel = cyc - start_cyc;
            if (rel == 1) chk(busy == 1'b1, "busy_cycle1", longint'(busy), 1);
            if (prev_stall)
                chk(fb_we && fb_addr == prev_addr && fb_data == prev_data, "stall_hold",
                    longint'({fb_we, fb_addr, fb_data}), longint'({1'b1, prev_addr, prev_data}));
            if (fb_we && fb_ready) begin
                n_wr++;
                if (first_we_rel < 0) begin
                    first_we_rel = rel;
                    first_addr   = int'(fb_addr);
                    first_data   = int'(fb_data);
                end
                last_addr = int'(fb_addr);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_write", longint'(fb_addr), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk(int'(fb_addr) == e.addr && int'(fb_data) == e.data, "write",
                        longint'(fb_addr) * 256 + longint'(fb_data), longint'(e.addr) * 256 + longint'(e.data));
                end
            end
            prev_stall = fb_we && !fb_ready;
            prev_addr  = fb_addr;
            prev_data  = fb_data;
            if (done) begin
                done_cnt++;
                done_rel = rel;
            end
            if (done_rel >= 0 && rel == done_rel + 1) chk(busy == 1'b0, "busy_after_done", longint'(busy), 0);
            if (addr_chk_en && busy) begin
                chk(int'(rom_addr) == exp_rom || int'(rom_addr) == exp_rom - 1, "rom_seq",
                    longint'(rom_addr), exp_rom);
                if (int'(rom_addr) == exp_rom) exp_rom++;
            end
        end
    end

    task automatic start_run(input int px, input int py, input bit flip);
        @(posedge Clk);
        #1;
        pos_x = 10'(px);
        pos_y = 10'(py);
`ifdef SPRITE_BLITTER_HFLIP_EN
        hflip = flip;
`else
        if (flip) $display("note: hflip requested without the mirroring build");
`endif
        start     = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int en, ef, el;
        bit finished;
        fill_rom(v.pat);
        build_expected(v.px, v.py, v.flip);
        en = (v.exp_n >= 0) ? v.exp_n : exp_q.size();
        ef = (v.exp_first >= 0) ? v.exp_first : ((exp_q.size() > 0) ? exp_q[0].addr : -1);
        el = (v.exp_last >= 0) ? v.exp_last : ((exp_q.size() > 0) ? exp_q[$].addr : -1);
        n_wr = 0; first_addr = -1; first_data = -1; last_addr = -1; first_we_rel = -1;
        done_cnt = 0; done_rel = -1; exp_rom = 0; prev_stall = 1'b0;
        addr_chk_en = !v.flip;
        fb_ready = 1'b1;
        start_run(v.px, v.py, v.flip);
        mon_en = 1'b1;
        finished = 1'b0;
        for (int k = 0; k < 30000; k++) begin
            @(posedge Clk);
            #1;
            start    = (v.poke && k == 200);
            if (start) begin
                pos_x = 10'd5;
                pos_y = 10'd5;
            end
            fb_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done_cnt > 0 && (cyc - start_cyc) >= done_rel + 3) begin
                finished = 1'b1;
                break;
            end
        end
        mon_en = 1'b0;
        start  = 1'b0;
        chk(finished, "done_timeout", longint'(finished), 1);
        chk(n_wr == en, "write_count", n_wr, en);
        chk(exp_q.size() == 0, "writes_missing", exp_q.size(), 0);
        if (en > 0) begin
            chk(first_addr == ef, "first_fb_addr", first_addr, ef);
            chk(last_addr == el, "last_fb_addr", last_addr, el);
        end
        chk(done_cnt == 1, "done_pulses", done_cnt, 1);
        if (v.exp_done >= 0) chk(done_rel == v.exp_done, "done_cycle", done_rel, v.exp_done);
        if (v.exp_first_we >= 0) chk(first_we_rel == v.exp_first_we, "first_we_cycle", first_we_rel, v.exp_first_we);
        if (addr_chk_en) chk(exp_rom == SPR_PIXELS, "rom_addrs_issued", exp_rom, SPR_PIXELS);
        $display("run %s: pos=(%0d,%0d) writes=%0d done_cycle=%0d", tag, v.px, v.py, n_wr, done_rel);
    endtask

    task automatic check_reset_outputs(input string name);
        chk(!busy && !done && !fb_we && rom_addr == 14'd0 && fb_addr == 19'd0 && fb_data == 8'd0, name,
            longint'({busy, done, fb_we, rom_addr, fb_addr, fb_data}), 0);
    endtask

    vec_t tbl[6];

    initial begin
        //          px    py   pattern     rdy poke flip  n     first  last   done  we1
        tbl[0] = '{   0,    0, PAT_OPAQUE, 0,  0,   0,  9216,     0, 60895, 9220,  3};
        tbl[1] = '{ 600,    0, PAT_OPAQUE, 0,  0,   0,  3840,   600, 61439,   -1,  3};
        tbl[2] = '{   0,    0, PAT_CHECK,  0,  0,   0,  4608,     1, 60894,   -1,  4};
        tbl[3] = '{   0,    0, PAT_OPAQUE, 1,  1,   0,  9216,     0, 60895,   -1, -1};
        tbl[4] = '{ 560,  400, PAT_RANDOM, 0,  0,   0,    -1,    -1,    -1,   -1, -1};
        tbl[5] = '{1000,  440, PAT_OPAQUE, 0,  0,   0,     0,    -1,    -1,   -1, -1};

        repeat (3) begin
            @(negedge Clk);
            check_reset_outputs("reset_state");
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Abort a run with reset at cycle 500, then run again from scratch.
        fill_rom(PAT_OPAQUE);
        start_run(0, 0, 1'b0);
        for (int k = 0; k < 600; k++) begin
            @(posedge Clk);
            #1;
            start = 1'b0;
            if (cyc - start_cyc == 500) break;
        end
        Reset_n = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            check_reset_outputs("reset_abort_outputs");
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            check_reset_outputs("post_reset_idle");
        end
        $display("run reset_abort: reset applied at cycle 500");
        run_vec(tbl[0], "after_reset");

`ifdef SPRITE_BLITTER_HFLIP_EN
        begin
            vec_t fv;
            fv = '{0, 0, PAT_RAMP, 0, 0, 1, -1, 0, -1, -1, 3};
            run_vec(fv, "hflip");
            chk(first_data == 95, "hflip_first_data", first_data, 95);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
